// File: rtl/bmp_stream_parser_if.sv
// ---------------------------------------------------------------------------
// bmp_stream_parser_if
//   Bundles the byte-stream input, the parsed header fields and the pixel
//   stream output of bmp_stream_parser.
//
//   Byte stream  : byte_valid / byte_data / byte_ready (valid/ready)
//   Header       : hdr_valid pulse with bmp_size, data_offset, bmp_width,
//                  bmp_height
//   Pixel stream : pix_valid / pix_ready / pix_data {R,G,B} / pix_x / pix_y
//                  with pix_sof, pix_eol, pix_eof markers
//   Status       : frame_done pulse, sticky err
//
//   master : the surrounding system (byte source, pixel sink)
//   slave  : the parser
// ---------------------------------------------------------------------------
interface bmp_stream_parser_if #(
  parameter int X_W = 12,
  parameter int Y_W = 12
);
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           byte_ready;
  logic           hdr_valid;
  logic [31:0]    bmp_size;
  logic [31:0]    data_offset;
  logic [31:0]    bmp_width;
  logic [31:0]    bmp_height;
  logic           pix_valid;
  logic           pix_ready;
  logic [23:0]    pix_data;
  logic [X_W-1:0] pix_x;
  logic [Y_W-1:0] pix_y;
  logic           pix_sof;
  logic           pix_eol;
  logic           pix_eof;
  logic           frame_done;
  logic           err;

  modport master (
    output byte_valid, byte_data, pix_ready,
    input  byte_ready, hdr_valid, bmp_size, data_offset, bmp_width, bmp_height,
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    input  frame_done, err
  );

  modport slave (
    input  byte_valid, byte_data, pix_ready,
    output byte_ready, hdr_valid, bmp_size, data_offset, bmp_width, bmp_height,
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
    output frame_done, err
  );
endinterface

// File: rtl/bmp_stream_parser.sv
// ---------------------------------------------------------------------------
// bmp_stream_parser
//   Receives a 24-bit BMP file as a byte stream in file order, parses the
//   54-byte file + info header, skips up to the pixel data offset, assembles
//   B,G,R triplets into {R,G,B} pixels, strips row padding and discards any
//   trailing bytes up to the declared file size.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : bmp_stream_parser_if.slave (byte stream in, header fields,
//             pixel stream out, frame_done pulse, sticky err)
// ---------------------------------------------------------------------------
module bmp_stream_parser #(
  parameter int X_W = 12,
  parameter int Y_W = 12
) (
  input logic                clk,
  input logic                rst_n,
  bmp_stream_parser_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR, S_SKIP, S_PIX, S_PAD, S_TAIL, S_ERR
  } state_e;

  typedef struct packed {
    logic [23:0]    data;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           sof;
    logic           eol;
    logic           eof;
  } pix_t;

  state_e         state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [7:0]     sig0_q, sig0_d;
  logic [31:0]    size_q, size_d;
  logic [31:0]    off_q, off_d;
  logic [31:0]    width_q, width_d;
  logic [31:0]    height_q, height_d;
  logic [15:0]    bpp_q, bpp_d;
  logic [31:0]    comp_q, comp_d;
  logic [1:0]     ph_q, ph_d;
  logic [7:0]     b_q, b_d;
  logic [7:0]     g_q, g_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [1:0]     pad_q, pad_d;
  pix_t           pix_q, pix_d;
  logic           pix_valid_q, pix_valid_d;
  logic           hdr_valid_q, hdr_valid_d;
  logic           frame_done_q, frame_done_d;
  logic           err_q, err_d;

  logic           byte_ready;
  logic           accept;
  logic           hdr_ok;
  logic           at_last_x;
  logic           at_last_y;
  logic           row_done;

  assign at_last_x = (x_q == (width_q[X_W-1:0] - X_W'(1)));
  assign at_last_y = (y_q == (height_q[Y_W-1:0] - Y_W'(1)));

  // Height must also be positive: a negative (top-down) height has bit 31 set
  // and therefore fails the upper-bits-zero test as well.
  assign hdr_ok = (bpp_q == 16'd24) && (comp_q == 32'd0) &&
                  (width_q != 32'd0) && ((width_q >> X_W) == 32'd0) &&
                  (height_q != 32'd0) && ((height_q >> Y_W) == 32'd0) &&
                  (off_q >= 32'd54);

  // Only the pixel state can stall the byte stream; TAIL stops taking bytes
  // once the declared size is reached so the next frame's byte 0 waits.
  always_comb begin
    byte_ready = 1'b1;
    case (state_q)
      S_PIX:   byte_ready = !(pix_valid_q && !bus.pix_ready);
      S_TAIL:  byte_ready = (cnt_q < size_q);
      default: byte_ready = 1'b1;
    endcase
  end

  assign accept = bus.byte_valid && byte_ready;

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    sig0_d       = sig0_q;
    size_d       = size_q;
    off_d        = off_q;
    width_d      = width_q;
    height_d     = height_q;
    bpp_d        = bpp_q;
    comp_d       = comp_q;
    ph_d         = ph_q;
    b_d          = b_q;
    g_d          = g_q;
    x_d          = x_q;
    y_d          = y_q;
    pad_d        = pad_q;
    pix_d        = pix_q;
    pix_valid_d  = pix_valid_q;
    hdr_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;
    row_done     = 1'b0;

    if (pix_valid_q && bus.pix_ready) pix_valid_d = 1'b0;
    if (accept) cnt_d = cnt_q + 32'd1;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (cnt_q == 32'd0) sig0_d = bus.byte_data;
          // Little-endian capture: byte lane k of each field sits at base+k.
          for (int k = 0; k < 4; k++) begin
            if (cnt_q == 32'(2 + k))  size_d[8*k +: 8]   = bus.byte_data;
            if (cnt_q == 32'(10 + k)) off_d[8*k +: 8]    = bus.byte_data;
            if (cnt_q == 32'(18 + k)) width_d[8*k +: 8]  = bus.byte_data;
            if (cnt_q == 32'(22 + k)) height_d[8*k +: 8] = bus.byte_data;
            if (cnt_q == 32'(30 + k)) comp_d[8*k +: 8]   = bus.byte_data;
          end
          for (int k = 0; k < 2; k++) begin
            if (cnt_q == 32'(28 + k)) bpp_d[8*k +: 8] = bus.byte_data;
          end
          if ((cnt_q == 32'd1) && !((sig0_q == 8'h42) && (bus.byte_data == 8'h4D))) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
          if (cnt_q == 32'd53) begin
            if (hdr_ok) begin
              hdr_valid_d = 1'b1;
              ph_d        = 2'd0;
              x_d         = '0;
              y_d         = '0;
              state_d     = (off_q > 32'd54) ? S_SKIP : S_PIX;
            end else begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
          end
        end
      end

      // Leave on the byte that brings the count to the offset, so the first
      // pixel byte is taken without a bubble.
      S_SKIP: begin
        if (accept && (cnt_d == off_q)) state_d = S_PIX;
      end

      S_PIX: begin
        if (accept) begin
          case (ph_q)
            2'd0: begin
              b_d  = bus.byte_data;
              ph_d = 2'd1;
            end
            2'd1: begin
              g_d  = bus.byte_data;
              ph_d = 2'd2;
            end
            default: begin
              ph_d        = 2'd0;
              pix_valid_d = 1'b1;
              pix_d.data  = {bus.byte_data, g_q, b_q};
              pix_d.x     = x_q;
              pix_d.y     = y_q;
              pix_d.sof   = (x_q == '0) && (y_q == '0);
              pix_d.eol   = at_last_x;
              pix_d.eof   = at_last_x && at_last_y;
              if (!at_last_x) begin
                x_d = x_q + X_W'(1);
              end else if (width_q[1:0] != 2'd0) begin
                // Rows are padded to 4 bytes; 3*w mod 4 makes the pad w mod 4.
                pad_d   = width_q[1:0];
                state_d = S_PAD;
              end else begin
                row_done = 1'b1;
              end
            end
          endcase
        end
      end

      S_PAD: begin
        if (accept) begin
          if (pad_q == 2'd1) row_done = 1'b1;
          else               pad_d    = pad_q - 2'd1;
        end
      end

      S_TAIL: begin
        if (cnt_d >= size_q) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_HDR;
        end
      end

      default: ;  // S_ERR: swallow bytes until reset
    endcase

    // End of a row (after its padding, if any). On the last row, finish the
    // frame at once when the declared size is already covered.
    if (row_done) begin
      x_d = '0;
      if (at_last_y) begin
        if (cnt_d >= size_q) begin
          frame_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_HDR;
        end else begin
          state_d = S_TAIL;
        end
      end else begin
        y_d     = y_q + Y_W'(1);
        state_d = S_PIX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR;
      cnt_q        <= '0;
      sig0_q       <= '0;
      size_q       <= '0;
      off_q        <= '0;
      width_q      <= '0;
      height_q     <= '0;
      bpp_q        <= '0;
      comp_q       <= '0;
      ph_q         <= '0;
      b_q          <= '0;
      g_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pad_q        <= '0;
      pix_q        <= '0;
      pix_valid_q  <= 1'b0;
      hdr_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // that were present before this edge.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sig0_q       <= sig0_d;
      size_q       <= size_d;
      off_q        <= off_d;
      width_q      <= width_d;
      height_q     <= height_d;
      bpp_q        <= bpp_d;
      comp_q       <= comp_d;
      ph_q         <= ph_d;
      b_q          <= b_d;
      g_q          <= g_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pad_q        <= pad_d;
      pix_q        <= pix_d;
      pix_valid_q  <= pix_valid_d;
      hdr_valid_q  <= hdr_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.byte_ready  = byte_ready;
  assign bus.hdr_valid   = hdr_valid_q;
  assign bus.bmp_size    = size_q;
  assign bus.data_offset = off_q;
  assign bus.bmp_width   = width_q;
  assign bus.bmp_height  = height_q;
  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_data    = pix_q.data;
  assign bus.pix_x       = pix_q.x;
  assign bus.pix_y       = pix_q.y;
  assign bus.pix_sof     = pix_q.sof;
  assign bus.pix_eol     = pix_q.eol;
  assign bus.pix_eof     = pix_q.eof;
  assign bus.frame_done  = frame_done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_bmp_stream_parser.sv
// ---------------------------------------------------------------------------
// tb_bmp_stream_parser
//   Builds BMP files as byte arrays, derives the expected header and pixel
//   list directly from the file layout (offset + row*stride + 3*col), and
//   compares the DUT's pixel and header outputs on every handshake.
// ---------------------------------------------------------------------------
module tb_bmp_stream_parser;
  localparam int X_W = 12;
  localparam int Y_W = 12;

  typedef struct packed {
    logic [23:0] d;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } pix_t;

  typedef struct {
    int unsigned size;
    int unsigned off;
    int unsigned w;
    int unsigned h;
  } hdr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bmp_stream_parser_if #(.X_W(X_W), .Y_W(Y_W)) bus ();
  bmp_stream_parser #(.X_W(X_W), .Y_W(Y_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int         total = 0;
  int         bad = 0;
  pix_t       exp_q[$];
  pix_t       got_q[$];
  hdr_t       exp_hdr_q[$];
  logic [7:0] fb[$];
  int         fd_cnt = 0;
  int         hdr_cnt = 0;
  int         pv_cnt = 0;
  int         ready_mode = 1;  // 0 random, 1 high, 2 low
  pix_t       mon_cur;
  pix_t       prev_p;
  logic       prev_stall = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel sink
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.pix_ready = 1'($urandom_range(0, 1));
        1:       bus.pix_ready = 1'b1;
        default: bus.pix_ready = 1'b0;
      endcase
    end
  end

  // Compare process
  always @(negedge clk) begin
    mon_cur = {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_sof, bus.pix_eol, bus.pix_eof};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.pix_valid) begin
        pv_cnt++;
        if (prev_stall) check("pix_hold", 64'(mon_cur), 64'(prev_p));
        if (bus.pix_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pix_unexpected: got %h with none expected", mon_cur);
          end else begin
            check("pix", 64'(mon_cur), 64'(exp_q.pop_front()));
          end
          got_q.push_back(mon_cur);
        end
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_p     = mon_cur;
      if (bus.hdr_valid) begin
        hdr_t h;
        hdr_cnt++;
        if (exp_hdr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL hdr_unexpected: got size %0d with none expected", bus.bmp_size);
        end else begin
          h = exp_hdr_q.pop_front();
          check("hdr_size",   64'(bus.bmp_size),    64'(h.size));
          check("hdr_offset", 64'(bus.data_offset), 64'(h.off));
          check("hdr_width",  64'(bus.bmp_width),   64'(h.w));
          check("hdr_height", 64'(bus.bmp_height),  64'(h.h));
        end
      end
      if (bus.frame_done) fd_cnt++;
    end
  end

  task automatic put(input int idx, input int unsigned v, input int n);
    for (int k = 0; k < n; k++) fb[idx + k] = 8'(v >> (8 * k));
  endtask

  // File image plus expectations derived from the BMP layout.
  task automatic build(input int w, input int h, input int off, input int size,
                       input int bpp, input logic [7:0] sig0, input bit rnd, input bit ok);
    int stride, dend, len, base;
    stride = ((3 * w + 3) / 4) * 4;
    dend   = off + stride * h;
    len    = (size > dend) ? size : dend;
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(rnd ? 8'($urandom) : 8'(i));
    for (int i = 0; i < 54; i++) fb[i] = 8'h00;
    fb[0] = sig0;
    fb[1] = 8'h4D;
    put(2, size, 4);
    put(10, off, 4);
    put(14, 40, 4);
    put(18, w, 4);
    put(22, h, 4);
    put(26, 1, 2);
    put(28, bpp, 2);
    if (ok) begin
      exp_hdr_q.push_back('{size, off, w, h});
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++) begin
          base = off + y * stride + 3 * x;
          exp_q.push_back(pix_t'({fb[base + 2], fb[base + 1], fb[base], 12'(x), 12'(y),
                                  (x == 0 && y == 0), (x == w - 1), (x == w - 1 && y == h - 1)}));
        end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    if ($urandom_range(0, 3) == 0) begin
      bus.byte_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    for (int n = 0; n < 200 && !bus.byte_ready; n++) @(negedge clk);
    check("byte_accept", 64'(bus.byte_ready), 64'(1));
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) send_byte(fb[i]);
  endtask

  task automatic finish_frame(input int fd0);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("pix_drain", 64'(exp_q.size()), 64'(0));
    repeat (4) @(negedge clk);
    check("frame_done_cnt", 64'(fd_cnt - fd0), 64'(1));
    check("hdr_seen", 64'(exp_hdr_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_hdr_q.delete();
    #2;
    check("rst_byte_ready", 64'(bus.byte_ready), 64'(1));
    check("rst_pix_valid",  64'(bus.pix_valid),  64'(0));
    check("rst_err",        64'(bus.err),        64'(0));
    check("rst_width",      64'(bus.bmp_width),  64'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, hc0, pv0, w, h, off, size, stride, dend;
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_byte_ready", 64'(bus.byte_ready), 64'(1));
    check("reset_pix_valid",  64'(bus.pix_valid),  64'(0));
    check("reset_hdr_valid",  64'(bus.hdr_valid),  64'(0));
    check("reset_frame_done", 64'(bus.frame_done), 64'(0));
    check("reset_err",        64'(bus.err),        64'(0));
    check("reset_bmp_size",   64'(bus.bmp_size),   64'(0));
    check("reset_pix_data",   64'(bus.pix_data),   64'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2x2, offset 54, size 70, pad 2
    ready_mode = 1;
    build(2, 2, 54, 70, 24, 8'h42, 0, 1);
    check("model_p0", 64'(exp_q[0].d), 64'h383736);
    check("model_p3", 64'(exp_q[3].d), 64'h434241);
    got_q.delete();
    fd0 = fd_cnt;
    send_range(0, 54);
    check("hdr_valid_after_53", 64'(bus.hdr_valid), 64'(1));
    send_range(54, 70);
    check("frame_done_after_69", 64'(bus.frame_done), 64'(1));
    finish_frame(fd0);
    check("p2x2_count", 64'(got_q.size()), 64'(4));
    check("p2x2_p0", 64'(got_q[0]), 64'({24'h383736, 12'd0, 12'd0, 3'b100}));
    check("p2x2_p1", 64'(got_q[1]), 64'({24'h3b3a39, 12'd1, 12'd0, 3'b010}));
    check("p2x2_p3", 64'(got_q[3]), 64'({24'h434241, 12'd1, 12'd1, 3'b011}));

    // 3x1, offset 58, size 70, pad 3
    build(3, 1, 58, 70, 24, 8'h42, 0, 1);
    check("model_3x1_p0", 64'(exp_q[0].d), 64'h3c3b3a);
    got_q.delete();
    fd0 = fd_cnt;
    send_range(0, 70);
    check("frame_done_3x1", 64'(bus.frame_done), 64'(1));
    finish_frame(fd0);
    check("p3x1_count", 64'(got_q.size()), 64'(3));
    check("p3x1_p2", 64'(got_q[2]), 64'({24'h424140, 12'd2, 12'd0, 3'b011}));

    // 2x2 with the first pixel stalled for 5 cycles
    build(2, 2, 54, 70, 24, 8'h42, 0, 1);
    got_q.delete();
    fd0 = fd_cnt;
    ready_mode = 2;
    fork
      send_range(0, 70);
      begin
        int n;
        for (n = 0; n < 3000 && !(bus.pix_valid && bus.pix_sof); n++) @(negedge clk);
        check("stall_seen_sof", 64'(bus.pix_valid && bus.pix_sof), 64'(1));
        for (int c = 0; c < 5; c++) begin
          if (c != 0) @(negedge clk);
          check("stall_pix_valid",  64'(bus.pix_valid),  64'(1));
          check("stall_pix_data",   64'(bus.pix_data),   64'h383736);
          check("stall_byte_ready", 64'(bus.byte_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
      end
    join
    finish_frame(fd0);
    check("stall_count", 64'(got_q.size()), 64'(4));
    check("stall_p2", 64'(got_q[2].d), 64'h403f3e);

    // Bad signature
    build(2, 2, 54, 70, 24, 8'h41, 0, 0);
    fd0 = fd_cnt; hc0 = hdr_cnt; pv0 = pv_cnt;
    send_byte(fb[0]);
    check("sig_err_before", 64'(bus.err), 64'(0));
    send_byte(fb[1]);
    check("sig_err_after", 64'(bus.err), 64'(1));
    send_range(2, 70);
    repeat (4) @(negedge clk);
    check("sig_no_hdr",  64'(hdr_cnt - hc0), 64'(0));
    check("sig_no_pix",  64'(pv_cnt - pv0),  64'(0));
    check("sig_no_done", 64'(fd_cnt - fd0),  64'(0));
    check("sig_err_sticky", 64'(bus.err), 64'(1));
    @(posedge clk);
    #1;
    do_reset();

    // bpp = 32
    build(2, 2, 54, 70, 32, 8'h42, 0, 0);
    fd0 = fd_cnt; hc0 = hdr_cnt; pv0 = pv_cnt;
    send_range(0, 53);
    check("bpp_err_before", 64'(bus.err), 64'(0));
    send_byte(fb[53]);
    check("bpp_err_after", 64'(bus.err), 64'(1));
    check("bpp_no_hdr_valid", 64'(bus.hdr_valid), 64'(0));
    send_range(54, 70);
    check("bpp_byte_ready", 64'(bus.byte_ready), 64'(1));
    repeat (3) @(negedge clk);
    check("bpp_no_hdr",  64'(hdr_cnt - hc0), 64'(0));
    check("bpp_no_pix",  64'(pv_cnt - pv0),  64'(0));
    check("bpp_no_done", 64'(fd_cnt - fd0),  64'(0));
    @(posedge clk);
    #1;
    do_reset();

    // Reset during the 3rd pixel, then a clean frame
    ready_mode = 1;
    build(2, 2, 54, 70, 24, 8'h42, 0, 1);
    send_range(0, 62);
    for (int i = 0; i < 50 && exp_q.size() != 2; i++) @(negedge clk);
    check("mid_two_done", 64'(exp_q.size()), 64'(2));
    @(posedge clk);
    #1;
    ready_mode = 2;
    send_range(62, 65);
    check("mid_pending", 64'(bus.pix_valid), 64'(1));
    do_reset();
    check("mid_hdr_valid", 64'(bus.hdr_valid), 64'(0));
    ready_mode = 1;
    build(3, 2, 56, 80, 24, 8'h42, 1, 1);
    fd0 = fd_cnt;
    send_range(0, fb.size());
    finish_frame(fd0);

    // Declared size already covered by the pixel data
    build(2, 2, 54, 60, 24, 8'h42, 1, 1);
    fd0 = fd_cnt;
    send_range(0, fb.size());
    check("short_size_done", 64'(bus.frame_done), 64'(1));
    finish_frame(fd0);

    // Random frames with random backpressure
    ready_mode = 0;
    for (int f = 0; f < 10; f++) begin
      w      = $urandom_range(1, 7);
      h      = $urandom_range(1, 5);
      off    = 54 + $urandom_range(0, 6);
      stride = ((3 * w + 3) / 4) * 4;
      dend   = off + stride * h;
      size   = ($urandom_range(0, 3) == 0) ? 54 + $urandom_range(0, 10)
                                           : dend + $urandom_range(0, 4);
      build(w, h, off, size, 24, 8'h42, 1, 1);
      fd0 = fd_cnt;
      send_range(0, fb.size());
      finish_frame(fd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bmp_stream_parser.md
Name: bmp_stream_parser

Overview:
- Synthesizable receiver for a 24-bit BMP file delivered as a byte stream, one byte per accepted cycle, in file order.
- This is the consuming end of the byte stream our BMP file dumper emits.
- Parses the 54-byte BITMAPFILEHEADER + BITMAPINFOHEADER, skips any gap up to the pixel data offset, assembles B,G,R triplets into pixels, strips row padding and discards trailing bytes.
- Feeds image-processing blocks with a valid/ready pixel stream.

Parameters:
- X_W, 12, width of the pixel column counter; max supported image width is 2^X_W-1.
- Y_W, 12, width of the pixel row counter; max supported image height is 2^Y_W-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- byte_valid  in  1  input byte present.
- byte_data  in  8  input byte, file order.
- byte_ready  out  1  byte accepted when byte_valid && byte_ready.
- hdr_valid  out  1  one-cycle pulse: header fields valid and checked.
- bmp_size  out  32  file size, bytes 2..5, little-endian.
- data_offset  out  32  pixel data offset, bytes 10..13.
- bmp_width  out  32  bytes 18..21.
- bmp_height  out  32  bytes 22..25.
- pix_valid  out  1  pixel output valid.
- pix_ready  in  1  downstream accepts pixel.
- pix_data  out  24  {R,G,B}.
- pix_x  out  X_W  column of pix_data.
- pix_y  out  Y_W  row index in file order (row 0 = bottom row).
- pix_sof  out  1  first pixel of frame, qualified by pix_valid.
- pix_eol  out  1  last pixel of row.
- pix_eof  out  1  last pixel of frame.
- frame_done  out  1  one-cycle pulse: bmp_size bytes consumed.
- err  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0 except byte_ready = 1; state HDR; byte counter cnt = 0; header fields 0.
- cnt is 32 bits and increments on every accepted byte. Header bytes are captured at their file index, little-endian.
- HDR (byte_ready = 1):
  - Signature is checked at cnt = 1: bytes 0,1 must be 0x42,0x4D.
  - At cnt = 53 these checks run: bpp (bytes 28..29) == 24; compression (bytes 30..33) == 0; width nonzero and < 2^X_W; height nonzero, positive and < 2^Y_W; data_offset >= 54.
  - Any check failing sets err and moves to ERR.
  - On pass: hdr_valid pulses the cycle after byte 53 is accepted. Next state is SKIP if data_offset > 54, otherwise PIX.
- SKIP: discards bytes until cnt == data_offset, then moves to PIX.
- PIX:
  - Byte phase 0/1/2 = B/G/R.
  - On R accept, pix_valid rises the next cycle, holding registered data, x, y and flags.
  - pix_valid stays high until pix_ready.
  - byte_ready = !(pix_valid && !pix_ready). This gives full throughput with pix_ready tied high.
  - After the last pixel of a row (x == width-1): if pad = width[1:0] is nonzero, go to PAD. Otherwise x wraps to 0 and y increments.
- PAD: discards exactly pad bytes, then returns to PIX with x = 0, y+1. After the last row's padding, go to TAIL.
- TAIL: discards bytes while cnt < bmp_size. frame_done pulses on the cycle cnt reaches bmp_size, or immediately if it has already been reached. Then the next state is HDR with cnt = 0. The sticky err is cleared only by reset.
- Flags:
  - pix_sof is set for x = 0, y = 0.
  - pix_eol is set for x = width-1.
  - pix_eof is set for pix_eol && y = height-1.
- ERR: byte_ready = 1; all bytes are discarded; no pixels, no hdr_valid. Exit is only via rst_n.
- Reset mid-frame (async) aborts immediately. A pending pix_valid is dropped.

Test Plan:
- 2x2 image, offset 54, size 70, pad 2 → hdr_valid after byte 53. Four pixels: (0,0) sof; (1,0) eol; (0,1); (1,1) eol+eof. Both pad pairs are skipped and frame_done fires after byte 69.
- 3x1 image, offset 58, size 70 → bytes 54..57 are skipped, 3 pixels are output, pad 3 is dropped, frame_done fires.
- 2x2 image with pix_ready low for 5 cycles after the first pixel → pix_valid and pix_data are held, byte_ready is 0, no byte is lost, and the output order is unchanged.
- Byte 0 = 0x41 → err = 1 after byte 1 is accepted, and pix_valid/hdr_valid never assert.
- bpp = 32 → err is set at byte 53, and later bytes are all accepted and discarded.
- rst_n is pulsed low during the 3rd pixel, then a valid frame is sent → all outputs return to reset values and the new frame parses correctly from byte 0.
